// File: rtl/inst_axi_rd_responder_pkg.sv
// Shared encodings and widths for the AXI4 read responder.
// Pure definitions: no logic, no latency, no flow control.
package inst_axi_rd_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } axi_rd_state_t;

  localparam int LEN_W      = 8;   // AXI4 arlen width
  localparam int BYTE_OFF_W = 2;   // byte-in-word offset bits dropped from araddr
  localparam int DATA_W     = 32;
  localparam int WAIT_W     = 4;   // holds LATENCY-1 for LATENCY up to 15

endpackage

// File: rtl/inst_axi_rd_responder_ram.sv
// resp_word_ram: 1W/1R word RAM, synchronous read (1 cycle), no reset, read returns pre-write data.
// No flow control: rd_en low holds rd_data, which lets the caller stall a presented beat.
module resp_word_ram
  import inst_axi_rd_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_axi_rd_responder.sv
// AXI4 read responder: one AR at a time, arlen+1 INCR beats from word RAM, first beat LATENCY+1 cycles after AR.
// rready low freezes the presented beat; arready only while idle, so at most one burst is in flight.
module inst_axi_rd_responder
  import inst_axi_rd_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           araddr,
  input  logic [LEN_W-1:0]      arlen,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rlast,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  output logic [31:0]           txn_cnt
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = (LATENCY > 0) ? WAIT_W'(LATENCY - 1) : '0;

  axi_rd_state_t          state_q, state_d;
  logic [WAIT_W-1:0]      wait_cnt_q;
  logic [LEN_W-1:0]       remain_q;
  logic [ADDR_WIDTH-1:0]  ptr_q;
  logic [31:0]            txn_cnt_q;
  logic [ADDR_WIDTH-1:0]  ar_word;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_en;
  logic                   ar_hs;
  logic [DATA_W-1:0]      ram_q;
  logic                   unused_araddr;

  assign ar_word       = araddr[ADDR_WIDTH+BYTE_OFF_W-1:BYTE_OFF_W];
  assign unused_araddr = ^{araddr[31:ADDR_WIDTH+BYTE_OFF_W], araddr[BYTE_OFF_W-1:0]};

  assign arready = (state_q == ST_IDLE) && !rst;
  assign ar_hs   = arvalid && arready;
  assign rvalid  = (state_q == ST_BURST);
  assign rlast   = rvalid && (remain_q == '0);
  assign rdata   = rvalid ? ram_q : '0;
  assign txn_cnt = txn_cnt_q;

  // The RAM is read one cycle ahead of each beat; rd_en marks that a new beat is due next cycle.
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = ptr_q;
    case (state_q)
      ST_IDLE: begin
        rd_addr = ar_word;
        if (ar_hs) begin
          state_d = (LATENCY == 0) ? ST_BURST : ST_WAIT;
          rd_en   = (LATENCY == 0);
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_BURST;
          rd_en   = 1'b1;
        end
      end
      ST_BURST: begin
        if (rready) begin
          if (remain_q == '0) state_d = ST_IDLE;
          else                rd_en   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      remain_q   <= '0;
      ptr_q      <= '0;
      txn_cnt_q  <= '0;
    end else begin
      state_q <= state_d;

      // ptr_q always names the next word to fetch; wraps at the top of RAM.
      if (rd_en)      ptr_q <= rd_addr + ADDR_WIDTH'(1);
      else if (ar_hs) ptr_q <= ar_word;

      if (ar_hs)
        remain_q <= arlen;
      else if (rvalid && rready && (remain_q != '0))
        remain_q <= remain_q - LEN_W'(1);

      if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      else                    wait_cnt_q <= '0;

      if (rvalid && rready && rlast) txn_cnt_q <= txn_cnt_q + 32'd1;
    end
  end

  resp_word_ram #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

endmodule
